shift_sequencer: RTL and testbench

- Controller in front of the gear-selector FSM (tt_Maquina). Accepts one high-level gear request at a time over a valid/ready handshake.
- Checks safety interlocks (brake, vehicle stopped), then drives timed button pulses on the selector's D/N/R/P inputs.
- After each pulse, waits for the selector's one-hot indicator outputs to confirm the step.
- Ends every request with a done pulse or an error pulse plus error code.

---
 rtl/shift_sequencer_pkg.sv | 62 ++++++
 rtl/shift_sequencer_gear_decode.sv | 36 +++
 rtl/shift_sequencer.sv | 155 +++++++++++++++
 tb/tb_shift_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared gear codes, error codes, FSM encoding and step-planning helpers
// for the gear-shift sequencer in front of the selector FSM.
package shift_pkg;

    localparam logic [2:0] GEAR_P       = 3'd0;
    localparam logic [2:0] GEAR_R       = 3'd1;
    localparam logic [2:0] GEAR_N       = 3'd2;
    localparam logic [2:0] GEAR_D1      = 3'd3;
    localparam logic [2:0] GEAR_D2      = 3'd4;
    localparam logic [2:0] GEAR_D3      = 3'd5;
    localparam logic [2:0] GEAR_D4      = 3'd6;
    localparam logic [2:0] GEAR_ILLEGAL = 3'd7;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_INTERLOCK = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd2;
    localparam logic [2:0] ERR_STATUS    = 3'd3;
    localparam logic [2:0] ERR_GEAR      = 3'd4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CHECK    = 3'd1;
    localparam logic [2:0] ST_PULSE    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_ERR      = 3'd6;

    typedef enum logic [1:0] {
        BTN_P = 2'd0,
        BTN_R = 2'd1,
        BTN_N = 2'd2,
        BTN_D = 2'd3
    } btn_t;

    function automatic logic is_drive(input logic [2:0] g);
        return (g >= GEAR_D1) && (g <= GEAR_D4);
    endfunction

    // Next button on the way from cur to target; a downshift within D goes via N.
    function automatic btn_t step_button(input logic [2:0] cur, input logic [2:0] target);
        btn_t b;
        case (target)
            GEAR_P:  b = BTN_P;
            GEAR_R:  b = BTN_R;
            GEAR_N:  b = BTN_N;
            default: b = (is_drive(cur) && (cur > target)) ? BTN_N : BTN_D;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] next_gear(input logic [2:0] cur, input logic [2:0] target);
        logic [2:0] nxt;
        case (step_button(cur, target))
            BTN_P:   nxt = GEAR_P;
            BTN_R:   nxt = GEAR_R;
            BTN_N:   nxt = GEAR_N;
            default: nxt = is_drive(cur) ? (cur + 3'd1) : GEAR_D1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/shift_sequencer_gear_decode.sv
// Turns the selector's seven indicator lines into a gear code; anything
// other than exactly one lit indicator decodes as GEAR_ILLEGAL.
module gear_decode
    import shift_pkg::*;
(
    input  logic       p1,
    input  logic       r1,
    input  logic       n1,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       d4,
    output logic [2:0] gear,
    output logic       onehot_ok
);

    logic [6:0] ind;
    assign ind = {d4, d3, d2, d1, n1, r1, p1};

    always_comb begin
        // NOTE: defaults come first so no path through the case can infer a latch.
        gear = GEAR_ILLEGAL;
        case (ind)
            7'b000_0001: gear = GEAR_P;
            7'b000_0010: gear = GEAR_R;
            7'b000_0100: gear = GEAR_N;
            7'b000_1000: gear = GEAR_D1;
            7'b001_0000: gear = GEAR_D2;
            7'b010_0000: gear = GEAR_D3;
            7'b100_0000: gear = GEAR_D4;
            default:     gear = GEAR_ILLEGAL;
        endcase
        onehot_ok = (gear != GEAR_ILLEGAL);
    end

endmodule

// File: rtl/shift_sequencer.sv
// Gear-shift sequencer: accepts one gear request, checks interlocks, then
// presses selector buttons one step at a time and waits for each to be confirmed.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_gear,
    output logic       req_ready,
    input  logic       brake,
    input  logic       stopped,
    input  logic       P1,
    input  logic       R1,
    input  logic       N1,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    input  logic       D4,
    output logic       btn_P,
    output logic       btn_R,
    output logic       btn_N,
    output logic       btn_D,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] err_code
);

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);

    logic [2:0] state;
    logic [2:0] target;
    logic [2:0] cur_gear;
    logic [2:0] expect_gear;
    btn_t       btn_sel;
    logic [7:0] cnt;
    logic [2:0] err_code_q;

    logic [2:0] ind_gear;
    logic       ind_ok;

    gear_decode u_decode (
        .p1        (P1),
        .r1        (R1),
        .n1        (N1),
        .d1        (D1),
        .d2        (D2),
        .d3        (D3),
        .d4        (D4),
        .gear      (ind_gear),
        .onehot_ok (ind_ok)
    );

    // NOTE: registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            target      <= GEAR_P;
            cur_gear    <= GEAR_P;
            expect_gear <= GEAR_P;
            btn_sel     <= BTN_P;
            cnt         <= '0;
            err_code_q  <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        target     <= req_gear;
                        err_code_q <= ERR_NONE;
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    cnt <= '0;
                    if (target == GEAR_ILLEGAL) begin
                        err_code_q <= ERR_GEAR;
                        state      <= ST_ERR;
                    end else if (!ind_ok) begin
                        err_code_q <= ERR_STATUS;
                        state      <= ST_ERR;
                    end else if (((target == GEAR_P) || (target == GEAR_R)) && !(brake && stopped)) begin
                        err_code_q <= ERR_INTERLOCK;
                        state      <= ST_ERR;
                    end else if ((ind_gear == GEAR_P) && (target != GEAR_P) && !brake) begin
                        err_code_q <= ERR_INTERLOCK;
                        state      <= ST_ERR;
                    end else if (target == ind_gear) begin
                        state <= ST_DONE;
                    end else begin
                        cur_gear    <= ind_gear;
                        btn_sel     <= step_button(ind_gear, target);
                        expect_gear <= next_gear(ind_gear, target);
                        state       <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        cnt   <= '0;
                        state <= ST_WAIT_ACK;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ind_ok && (ind_gear == expect_gear)) begin
                        cnt      <= '0;
                        cur_gear <= expect_gear;
                        state    <= ST_GAP;
                    end else if (cnt == ACK_LAST) begin
                        err_code_q <= ERR_TIMEOUT;
                        state      <= ST_ERR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (cur_gear == target) begin
                            state <= ST_DONE;
                        end else begin
                            btn_sel     <= step_button(cur_gear, target);
                            expect_gear <= next_gear(cur_gear, target);
                            state       <= ST_PULSE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Buttons decode straight from state, so only the selected one can be high.
    assign btn_P     = (state == ST_PULSE) && (btn_sel == BTN_P);
    assign btn_R     = (state == ST_PULSE) && (btn_sel == BTN_R);
    assign btn_N     = (state == ST_PULSE) && (btn_sel == BTN_N);
    assign btn_D     = (state == ST_PULSE) && (btn_sel == BTN_D);
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a selector stub answers button presses
// and a per-request monitor records pulses, gaps and completion timing.
module tb_shift_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, req_valid, brake, stopped;
    logic [2:0] req_gear;
    logic       req_ready, btn_P, btn_R, btn_N, btn_D, busy, done, err;
    logic [2:0] err_code;
    logic [6:0] ind;  // bit i lit means the indicator of gear code i is on

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    shift_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_gear  (req_gear),
        .req_ready (req_ready),
        .brake     (brake),
        .stopped   (stopped),
        .P1        (ind[0]),
        .R1        (ind[1]),
        .N1        (ind[2]),
        .D1        (ind[3]),
        .D2        (ind[4]),
        .D3        (ind[5]),
        .D4        (ind[6]),
        .btn_P     (btn_P),
        .btn_R     (btn_R),
        .btn_N     (btn_N),
        .btn_D     (btn_D),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    localparam logic [3:0] B_P = 4'b0001;
    localparam logic [3:0] B_R = 4'b0010;
    localparam logic [3:0] B_N = 4'b0100;
    localparam logic [3:0] B_D = 4'b1000;

    int checks = 0;
    int errors = 0;

    logic       stub_on;
    logic [3:0] btn_prev;
    logic [3:0] seq[$];
    int n_p, n_r, n_n, n_d, n_done, n_err, multi;
    int min_w, max_w, cur_w, min_gap, cur_gap;
    int first_btn_cyc, done_cyc, err_cyc, t0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Selector model: a press takes effect once the button is released.
    function automatic logic [6:0] stub_next(input logic [6:0] cur_ind, input logic [3:0] b);
        int g = 0;
        for (int i = 0; i < 7; i++) if (cur_ind[i]) g = i;
        case (b)
            B_P: return 7'b000_0001;
            B_R: return 7'b000_0010;
            B_N: return 7'b000_0100;
            B_D: return (g < 3) ? 7'b000_1000 : ((g < 6) ? (cur_ind << 1) : cur_ind);
            default: return cur_ind;
        endcase
    endfunction

    task automatic clear_stats();
        seq.delete();
        n_p = 0; n_r = 0; n_n = 0; n_d = 0; n_done = 0; n_err = 0; multi = 0;
        min_w = 1000; max_w = 0; cur_w = 0; min_gap = 1000; cur_gap = 0;
        first_btn_cyc = -1; done_cyc = -1; err_cyc = -1;
    endtask

    task automatic tick();
        logic [3:0] btns;
        @(negedge clk);
        btns = {btn_D, btn_N, btn_R, btn_P};
        if ($countones(btns) > 1) multi++;
        if (btns != 4'b0) begin
            if (btn_prev == 4'b0) begin
                seq.push_back(btns);
                if (first_btn_cyc < 0) first_btn_cyc = cyc;
                if (seq.size() > 1 && cur_gap < min_gap) min_gap = cur_gap;
                cur_w = 0;
                if (btns == B_P) n_p++;
                if (btns == B_R) n_r++;
                if (btns == B_N) n_n++;
                if (btns == B_D) n_d++;
            end
            cur_w++;
        end else begin
            if (btn_prev != 4'b0) begin
                if (cur_w < min_w) min_w = cur_w;
                if (cur_w > max_w) max_w = cur_w;
                cur_gap = 0;
                if (stub_on) ind = stub_next(ind, btn_prev);
            end
            cur_gap++;
        end
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (err) begin
            n_err++;
            if (err_cyc < 0) err_cyc = cyc;
        end
        btn_prev = btns;
    endtask

    task automatic start_req(input logic [2:0] g);
        clear_stats();
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        check("ready_before_req", int'(req_ready), 1);
        req_valid = 1'b1;
        req_gear  = g;
        t0        = cyc;
        tick();
        req_valid = 1'b0;
        req_gear  = 3'd7;  // must be ignored after acceptance
        check("busy_after_accept", int'(busy), 1);
        check("ready_low_when_busy", int'(req_ready), 0);
    endtask

    task automatic finish_req();
        int n = 0;
        while (done_cyc < 0 && err_cyc < 0 && n < 300) begin
            tick();
            n++;
        end
        check("req_finished", int'(done_cyc >= 0 || err_cyc >= 0), 1);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_gear = 3'd0;
        brake = 1'b1; stopped = 1'b1; ind = 7'b000_0100; stub_on = 1'b1;
        btn_prev = 4'b0;
        clear_stats();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tick();
        check("rst_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_btns", int'({btn_D, btn_N, btn_R, btn_P}), 0);
        check("rst_done_err", int'({done, err}), 0);
        check("rst_code", int'(err_code), 0);

        // N -> D1: one D press
        ind = 7'b000_0100;
        start_req(3'd3);
        finish_req();
        check("t1_d_presses", n_d, 1);
        check("t1_other_presses", n_p + n_r + n_n, 0);
        check("t1_first_btn", first_btn_cyc - t0, 2);
        check("t1_min_width", min_w, 2);
        check("t1_max_width", max_w, 2);
        check("t1_done_latency", done_cyc - t0, 7);
        check("t1_done_pulses", n_done, 1);
        check("t1_err_pulses", n_err, 0);
        check("t1_code", int'(err_code), 0);
        check("t1_gear", int'(ind), 7'b000_1000);

        // N -> D4: four D presses
        ind = 7'b000_0100;
        start_req(3'd6);
        finish_req();
        check("t2_d_presses", n_d, 4);
        check("t2_total_presses", seq.size(), 4);
        check("t2_gap_ge_2", int'(min_gap >= 2), 1);
        check("t2_done_latency", done_cyc - t0, 22);
        check("t2_code", int'(err_code), 0);
        check("t2_gear", int'(ind), 7'b100_0000);

        // D3 -> D2: N, then D, D
        ind = 7'b010_0000;
        start_req(3'd4);
        finish_req();
        check("t3_presses", seq.size(), 3);
        check("t3_press0_n", int'(seq[0]), int'(B_N));
        check("t3_press1_d", int'(seq[1]), int'(B_D));
        check("t3_press2_d", int'(seq[2]), int'(B_D));
        check("t3_one_hot_btns", multi, 0);
        check("t3_done_latency", done_cyc - t0, 17);
        check("t3_gear", int'(ind), 7'b001_0000);

        // D2 -> R while moving
        ind = 7'b001_0000; brake = 1'b1; stopped = 1'b0;
        start_req(3'd1);
        finish_req();
        check("t4_err_time", err_cyc - t0, 2);
        check("t4_code_hold", int'(err_code), 1);
        check("t4_no_press", seq.size(), 0);
        check("t4_no_done", n_done, 0);
        check("t4_err_pulses", n_err, 1);

        // leaving P without brake
        ind = 7'b000_0001; brake = 1'b0; stopped = 1'b1;
        start_req(3'd2);
        finish_req();
        check("t4b_err_time", err_cyc - t0, 2);
        check("t4b_code", int'(err_code), 1);
        brake = 1'b1;

        // N -> P with an unresponsive selector
        ind = 7'b000_0100; stub_on = 1'b0;
        start_req(3'd0);
        check("t5_code_cleared", int'(err_code), 0);
        finish_req();
        check("t5_err_time", err_cyc - t0, 20);
        check("t5_code", int'(err_code), 2);
        check("t5_p_presses", n_p, 1);
        stub_on = 1'b1;

        // bad indicators, then illegal gear taking priority over them
        ind = 7'b000_1100;
        start_req(3'd3);
        finish_req();
        check("t7_err_time", err_cyc - t0, 2);
        check("t7_code", int'(err_code), 3);
        start_req(3'd7);
        finish_req();
        check("t8_err_time", err_cyc - t0, 2);
        check("t8_code", int'(err_code), 4);
        reset = 1'b1;
        tick();
        check("rst_clears_code", int'(err_code), 0);
        reset = 1'b0;
        tick();

        // target already engaged
        ind = 7'b001_0000;
        start_req(3'd4);
        finish_req();
        check("t9_done_time", done_cyc - t0, 2);
        check("t9_no_press", seq.size(), 0);

        // reset in the middle of a pulse
        ind = 7'b000_0100;
        start_req(3'd6);
        tick();
        check("t6_btn_d_in_pulse", int'(btn_D), 1);
        reset = 1'b1;
        tick();
        check("t6_btn_d_after_rst", int'(btn_D), 0);
        check("t6_busy_after_rst", int'(busy), 0);
        check("t6_ready_after_rst", int'(req_ready), 1);
        reset = 1'b0;
        tick();
        check("t6_still_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
